ucsbece154a_pwrmgr: RTL and testbench

IoT power manager for the multicycle RISC-V core. It sits beside the controller and consumes its sleep-entry request. It gates the datapath clock enable while the core sleeps and resumes the core on either a synchronized external wake pin or a programmable cycle timer. Wake is returned to the controller as a one-cycle pulse that moves it from the Sleep state back to Fetch.

---
 rtl/ucsbece154a_pwrmgr_pkg.sv | 30 +++
 rtl/ucsbece154a_sync2.sv | 31 +++
 rtl/ucsbece154a_pwrmgr.sv | 194 +++++++++++++++++++
 tb/tb_ucsbece154a_pwrmgr.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ucsbece154a_pwrmgr_pkg.sv
// ucsbece154a_pwrmgr_pkg
//   Shared constants for the power manager: FSM state encodings (2-bit,
//   kept next to the controller state constants) and wake-source codes.
//   Also carries a small helper that folds the two wake events into the
//   2-bit wake-source code.
package ucsbece154a_pwrmgr_pkg;

  typedef enum logic [1:0] {
    pwrmgr_ACTIVE = 2'b00,
    pwrmgr_DRAIN  = 2'b01,
    pwrmgr_SLEEP  = 2'b10,
    pwrmgr_WAKE   = 2'b11
  } pwrmgr_state_e;

  localparam logic [1:0] WAKE_SRC_NONE  = 2'b00;
  localparam logic [1:0] WAKE_SRC_PIN   = 2'b01;
  localparam logic [1:0] WAKE_SRC_TIMER = 2'b10;
  localparam logic [1:0] WAKE_SRC_BOTH  = 2'b11;

  // Bit 0 = pin, bit 1 = timer, so simultaneous events give BOTH.
  function automatic logic [1:0] wake_src_code(input logic pin_evt,
                                               input logic tmr_evt);
    logic [1:0] code;
    code = WAKE_SRC_NONE;
    if (pin_evt) code = code | WAKE_SRC_PIN;
    if (tmr_evt) code = code | WAKE_SRC_TIMER;
    return code;
  endfunction

endpackage

// File: rtl/ucsbece154a_sync2.sv
// ucsbece154a_sync2
//   Two-flop synchronizer for asynchronous single-bit inputs, with a
//   synchronous active-high reset to 0. Reusable for any async IoT input.
// Ports:
//   clk    in  clock
//   reset  in  synchronous, active-high reset
//   d_i    in  asynchronous input
//   q_o    out synchronized copy of d_i (two cycles of latency)
module ucsbece154a_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/ucsbece154a_pwrmgr.sv
// ucsbece154a_pwrmgr
//   Power manager for the multicycle RISC-V core. Consumes the controller's
//   sleep request, lets in-flight writes drain, gates the datapath clock
//   enable while asleep, and resumes on a synchronized wake-pin rising edge
//   or (when PWRMGR_TIMER_EN is defined) a programmable cycle timer. The
//   wake is returned as a one-cycle pulse in the first ACTIVE cycle.
//
// Configuration macro:
//   PWRMGR_TIMER_EN  defined   -> timer wake present
//                    undefined -> timer removed, wake_timeout_i ignored,
//                                 only the pin wakes, wake_src_o[1] = 0
// Ports:
//   clk             in   clock
//   reset           in   synchronous, active-high reset
//   sleep_req_i     in   sleep request pulse from the controller
//   wake_timeout_i  in   sleep duration in cycles, 0 disables the timer
//   wake_pin_i      in   asynchronous wake pin, rising-edge sensitive
//   clk_en_o        out  datapath/controller clock enable
//   wake_o          out  one-cycle wake pulse to the controller
//   sleeping_o      out  high in SLEEP and WAKE
//   wake_src_o      out  01 pin, 10 timer, 11 both
//   sleep_cycles_o  out  cumulative SLEEP cycles, saturating
//   state_o         out  current FSM state (debug observation)
//
// Handshake: sleep_req_i is a single-cycle strobe with no ready; it is
// accepted only in ACTIVE and ignored in every other state. wake_o is a
// single-cycle strobe that always coincides with clk_en_o = 1.
module ucsbece154a_pwrmgr
  import ucsbece154a_pwrmgr_pkg::*;
#(
  parameter int TIMER_W       = 16,
  parameter int CNT_W         = 32,
  parameter int DRAIN_CYCLES  = 2,
  parameter int WARMUP_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sleep_req_i,
  input  logic [TIMER_W-1:0] wake_timeout_i,
  input  logic               wake_pin_i,
  output logic               clk_en_o,
  output logic               wake_o,
  output logic               sleeping_o,
  output logic [1:0]         wake_src_o,
  output logic [CNT_W-1:0]   sleep_cycles_o,
  output logic [1:0]         state_o
);

  // One phase counter serves both DRAIN and WAKE; size it for the longer.
  localparam int PH_MAX = (DRAIN_CYCLES > WARMUP_CYCLES) ? DRAIN_CYCLES
                                                          : WARMUP_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam logic [PH_W-1:0] DRAIN_LAST  = PH_W'(DRAIN_CYCLES - 1);
  localparam logic [PH_W-1:0] WARMUP_LAST = PH_W'(WARMUP_CYCLES - 1);

  pwrmgr_state_e      state_q, state_d;
  logic [PH_W-1:0]    ph_q, ph_d;
  logic [1:0]         wake_src_q, wake_src_d;
  logic [CNT_W-1:0]   sleep_cycles_q, sleep_cycles_d;
  logic               clk_en_q, clk_en_d;
  logic               wake_q, wake_d;
  logic               sleeping_q, sleeping_d;
  logic               pin_prev_q;

  logic               pin_sync;
  logic               pin_edge;
  logic               timer_hit;

  ucsbece154a_sync2 u_pin_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (wake_pin_i),
    .q_o   (pin_sync)
  );

  // Edge detect runs in every state; only DRAIN and SLEEP act on it.
  assign pin_edge = pin_sync & ~pin_prev_q;

`ifdef PWRMGR_TIMER_EN
  logic [TIMER_W-1:0] timer_q, timer_d;

  // Wake fires on the 1 -> 0 step; a zero timer never fires.
  assign timer_hit = (state_q == pwrmgr_SLEEP) &&
                     (timer_q == TIMER_W'(1));
`else
  logic unused_wake_timeout;

  assign unused_wake_timeout = ^wake_timeout_i;
  assign timer_hit           = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    ph_d           = ph_q;
    wake_src_d     = wake_src_q;
    sleep_cycles_d = sleep_cycles_q;
    wake_d         = 1'b0;
`ifdef PWRMGR_TIMER_EN
    timer_d        = timer_q;
`endif

    case (state_q)
      pwrmgr_ACTIVE: begin
        if (sleep_req_i) begin
          state_d    = pwrmgr_DRAIN;
          ph_d       = '0;
          wake_src_d = WAKE_SRC_NONE;
`ifdef PWRMGR_TIMER_EN
          timer_d    = wake_timeout_i;
`endif
        end
      end

      pwrmgr_DRAIN: begin
        // A pin edge here is remembered so SLEEP is skipped entirely.
        if (pin_edge) wake_src_d = WAKE_SRC_PIN;
        if (ph_q == DRAIN_LAST) begin
          ph_d    = '0;
          state_d = (wake_src_q[0] | pin_edge) ? pwrmgr_WAKE : pwrmgr_SLEEP;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end

      pwrmgr_SLEEP: begin
        if (sleep_cycles_q != {CNT_W{1'b1}})
          sleep_cycles_d = sleep_cycles_q + CNT_W'(1);
`ifdef PWRMGR_TIMER_EN
        if (timer_q != '0) timer_d = timer_q - TIMER_W'(1);
`endif
        if (pin_edge || timer_hit) begin
          state_d    = pwrmgr_WAKE;
          ph_d       = '0;
          wake_src_d = wake_src_code(pin_edge, timer_hit);
        end
      end

      pwrmgr_WAKE: begin
        if (ph_q == WARMUP_LAST) begin
          state_d = pwrmgr_ACTIVE;
          ph_d    = '0;
          wake_d  = 1'b1;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end

      default: begin
        state_d = pwrmgr_ACTIVE;
        ph_d    = '0;
      end
    endcase

    // Outputs are registered copies of what the next state implies.
    clk_en_d   = (state_d == pwrmgr_ACTIVE) || (state_d == pwrmgr_DRAIN);
    sleeping_d = (state_d == pwrmgr_SLEEP)  || (state_d == pwrmgr_WAKE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= pwrmgr_ACTIVE;
      ph_q           <= '0;
      wake_src_q     <= WAKE_SRC_NONE;
      sleep_cycles_q <= '0;
      clk_en_q       <= 1'b1;
      wake_q         <= 1'b0;
      sleeping_q     <= 1'b0;
      pin_prev_q     <= 1'b0;
`ifdef PWRMGR_TIMER_EN
      timer_q        <= '0;
`endif
    end else begin
      state_q        <= state_d;
      ph_q           <= ph_d;
      wake_src_q     <= wake_src_d;
      sleep_cycles_q <= sleep_cycles_d;
      clk_en_q       <= clk_en_d;
      wake_q         <= wake_d;
      sleeping_q     <= sleeping_d;
      pin_prev_q     <= pin_sync;
`ifdef PWRMGR_TIMER_EN
      timer_q        <= timer_d;
`endif
    end
  end

  assign clk_en_o       = clk_en_q;
  assign wake_o         = wake_q;
  assign sleeping_o     = sleeping_q;
  assign wake_src_o     = wake_src_q;
  assign sleep_cycles_o = sleep_cycles_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_ucsbece154a_pwrmgr.sv
// tb_ucsbece154a_pwrmgr
//   Directed bench for the power manager with default parameters
//   (DRAIN_CYCLES=2, WARMUP_CYCLES=4). A cycle table covers the pin-wake
//   path; hand-written sequences cover DRAIN pin wake, timer/simultaneous
//   wake (or the timer-less build), and reset in SLEEP.
module tb_ucsbece154a_pwrmgr;

  localparam logic [1:0] ST_A = 2'd0;
  localparam logic [1:0] ST_D = 2'd1;
  localparam logic [1:0] ST_S = 2'd2;
  localparam logic [1:0] ST_W = 2'd3;

  logic        clk;
  logic        reset;
  logic        sleep_req_i;
  logic [15:0] wake_timeout_i;
  logic        wake_pin_i;
  logic        clk_en_o;
  logic        wake_o;
  logic        sleeping_o;
  logic [1:0]  wake_src_o;
  logic [31:0] sleep_cycles_o;
  logic [1:0]  state_o;

  int tests;
  int fails;

  ucsbece154a_pwrmgr dut (
    .clk            (clk),
    .reset          (reset),
    .sleep_req_i    (sleep_req_i),
    .wake_timeout_i (wake_timeout_i),
    .wake_pin_i     (wake_pin_i),
    .clk_en_o       (clk_en_o),
    .wake_o         (wake_o),
    .sleeping_o     (sleeping_o),
    .wake_src_o     (wake_src_o),
    .sleep_cycles_o (sleep_cycles_o),
    .state_o        (state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; inputs/outputs are touched 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, " clk_en"},   {31'd0, clk_en_o},   32'd1);
    chk({nm, " wake"},     {31'd0, wake_o},     32'd0);
    chk({nm, " sleeping"}, {31'd0, sleeping_o}, 32'd0);
    chk({nm, " src"},      {30'd0, wake_src_o}, 32'd0);
    chk({nm, " cycles"},   sleep_cycles_o,      32'd0);
    chk({nm, " state"},    {30'd0, state_o},    {30'd0, ST_A});
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    sleep_req_i    = 1'b0;
    wake_pin_i     = 1'b0;
    wake_timeout_i = 16'd0;
    tick();
    tick();
    chk_reset_vals("reset");
    reset = 1'b0;
    tick();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        req;
    logic        pin;
    logic        clk_en;
    logic        wake;
    logic        sleeping;
    logic [1:0]  src;
    logic [1:0]  st;
    logic [31:0] cyc;
  } vec_t;

  // Row i: inputs held during cycle i, outputs expected in cycle i+1.
  vec_t vecs[16];

  initial begin
    tests = 0;
    fails = 0;

    //          req  pin  clk_en wake sleep src    state cycles
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, ST_D, 32'd0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, ST_D, 32'd0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, ST_S, 32'd0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, ST_S, 32'd1};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, ST_S, 32'd2};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, ST_W, 32'd3};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, ST_W, 32'd3};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, ST_W, 32'd3};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, ST_W, 32'd3};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01, ST_A, 32'd3};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, ST_A, 32'd3};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01, ST_A, 32'd3};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, ST_A, 32'd3};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, ST_A, 32'd3};
    vecs[14] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, ST_A, 32'd3};
    vecs[15] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, ST_A, 32'd3};

    // ---- pin wake from SLEEP (timeout 0), table driven ----
    do_reset();
    for (int i = 0; i < 16; i++) begin
      sleep_req_i    = vecs[i].req;
      wake_pin_i     = vecs[i].pin;
      wake_timeout_i = 16'd0;
      tick();
      chk($sformatf("vec%0d clk_en", i),   {31'd0, clk_en_o},   {31'd0, vecs[i].clk_en});
      chk($sformatf("vec%0d wake", i),     {31'd0, wake_o},     {31'd0, vecs[i].wake});
      chk($sformatf("vec%0d sleeping", i), {31'd0, sleeping_o}, {31'd0, vecs[i].sleeping});
      chk($sformatf("vec%0d src", i),      {30'd0, wake_src_o}, {30'd0, vecs[i].src});
      chk($sformatf("vec%0d state", i),    {30'd0, state_o},    {30'd0, vecs[i].st});
      chk($sformatf("vec%0d cycles", i),   sleep_cycles_o,      vecs[i].cyc);
    end

    // ---- pin edge detected in DRAIN: DRAIN -> WAKE, SLEEP skipped ----
    do_reset();
    for (int k = 0; k < 9; k++) begin
      logic [1:0] exp_st;
      sleep_req_i = (k == 0);
      wake_pin_i  = 1'b1;
      tick();
      // now in cycle k+1
      exp_st = (k + 1 <= 2) ? ST_D : (k + 1 <= 6) ? ST_W : ST_A;
      chk($sformatf("drainpin c%0d state", k + 1), {30'd0, state_o}, {30'd0, exp_st});
      chk($sformatf("drainpin c%0d wake", k + 1), {31'd0, wake_o},
          {31'd0, (k + 1 == 7)});
      chk($sformatf("drainpin c%0d cycles", k + 1), sleep_cycles_o, 32'd0);
      if (k + 1 == 3)
        chk("drainpin src", {30'd0, wake_src_o}, 32'd1);
    end
    wake_pin_i = 1'b0;

`ifdef PWRMGR_TIMER_EN
    // ---- timer wake: T=10, clk_en low cycles 3..16, wake_o at 17 ----
    do_reset();
    for (int k = 0; k < 19; k++) begin
      sleep_req_i    = (k == 0);
      wake_timeout_i = 16'd10;
      tick();
      chk($sformatf("timer c%0d clk_en", k + 1), {31'd0, clk_en_o},
          {31'd0, !((k + 1 >= 3) && (k + 1 <= 16))});
      chk($sformatf("timer c%0d wake", k + 1), {31'd0, wake_o},
          {31'd0, (k + 1 == 17)});
      if (k + 1 == 17) begin
        chk("timer src", {30'd0, wake_src_o}, 32'd2);
        chk("timer cycles", sleep_cycles_o, 32'd10);
      end
    end

    // ---- simultaneous: T=5, pin edge detected when timer hits 0 ----
    do_reset();
    begin
      int pulses;
      pulses = 0;
      for (int k = 0; k < 16; k++) begin
        sleep_req_i    = (k == 0);
        wake_timeout_i = 16'd5;
        wake_pin_i     = (k >= 5);
        tick();
        if (wake_o) pulses++;
        if (k + 1 == 7)
          chk("simul pre state", {30'd0, state_o}, {30'd0, ST_S});
        if (k + 1 == 8) begin
          chk("simul state", {30'd0, state_o}, {30'd0, ST_W});
          chk("simul src", {30'd0, wake_src_o}, 32'd3);
        end
        if (k + 1 == 12)
          chk("simul wake", {31'd0, wake_o}, 32'd1);
      end
      chk("simul pulses", pulses, 32'd1);
      wake_pin_i = 1'b0;
    end
`else
    // ---- timer-less build: T=5 ignored, only the pin wakes ----
    do_reset();
    for (int k = 0; k < 23; k++) begin
      sleep_req_i    = (k == 0);
      wake_timeout_i = 16'd5;
      wake_pin_i     = (k >= 15);
      tick();
      if (k + 1 == 15) begin
        chk("notimer asleep", {31'd0, sleeping_o}, 32'd1);
        chk("notimer state", {30'd0, state_o}, {30'd0, ST_S});
        chk("notimer cycles", sleep_cycles_o, 32'd12);
      end
      if (k + 1 == 18) begin
        chk("notimer wstate", {30'd0, state_o}, {30'd0, ST_W});
        chk("notimer src", {30'd0, wake_src_o}, 32'd1);
      end
      chk($sformatf("notimer c%0d wake", k + 1), {31'd0, wake_o},
          {31'd0, (k + 1 == 22)});
    end
    wake_pin_i = 1'b0;
`endif

    // ---- reset while in SLEEP ----
    do_reset();
    sleep_req_i    = 1'b1;
    wake_timeout_i = 16'd0;
    tick();
    sleep_req_i = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    chk("midsleep sleeping", {31'd0, sleeping_o}, 32'd1);
    chk("midsleep cycles", sleep_cycles_o, 32'd4);
    reset = 1'b1;
    tick();
    chk_reset_vals("midsleep rst");
    reset = 1'b0;
    tick();
    chk_reset_vals("midsleep after");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
